// File: rtl/dmem_responder.sv
// Wait-stated, byte-addressable data RAM that answers the core's data-memory port.
// Optional macro DMEM_ACCESS_COUNT_EN adds load_count/store_count completion counters.
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_done,
    output logic              stall,
    output logic              err
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [31:0]       load_count,
    output logic [31:0]       store_count
`endif
);

    localparam int         WORDS     = 2 ** (ADDR_W - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]        cnt;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [2:0]        req_funct3;
    logic              req_rd;
    logic              req_wr;

    logic              capture;
    logic              do_access;

    logic              acc_rd;
    logic              acc_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [2:0]        acc_funct3;
    logic              f3_bad;
    logic              misalign;
    logic              acc_err;

    logic [DATA_W-1:0] mem [0:WORDS-1];
    logic [ADDR_W-3:0] word_idx;
    logic [DATA_W-1:0] rd_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] load_val;
    logic [3:0]        be;
    logic [DATA_W-1:0] st_data;
    logic              mem_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (rd || wr) begin
                    state_next = NO_WAIT ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Control strobes are forced low while reset is held so a request the core
    // keeps asserting neither stalls it nor reaches the RAM.
    always_comb begin
        stall     = 1'b0;
        capture   = 1'b0;
        do_access = 1'b0;
        if (reset) begin
            case (state)
                S_IDLE: begin
                    capture   = rd | wr;
                    stall     = (rd | wr) & ~NO_WAIT;
                    do_access = (rd | wr) & NO_WAIT;
                end
                S_WAIT: begin
                    stall     = 1'b1;
                    do_access = (cnt == 4'd1);
                end
                default: ;
            endcase
        end
    end

    // With no wait states the access happens on the capture edge, so it must
    // use the live request rather than the captured copy.
    always_comb begin
        if (state == S_IDLE) begin
            acc_rd     = rd;
            acc_wr     = wr;
            acc_addr   = addr;
            acc_wdata  = wr_data;
            acc_funct3 = funct3;
        end else begin
            acc_rd     = req_rd;
            acc_wr     = req_wr;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
            acc_funct3 = req_funct3;
        end
    end

    always_comb begin
        if (acc_rd) begin
            f3_bad = (acc_funct3 == 3'b011) || (acc_funct3[2:1] == 2'b11);
        end else begin
            f3_bad = (acc_funct3 > 3'b010);
        end
        misalign = ((acc_funct3[1:0] == 2'b01) && acc_addr[0]) ||
                   ((acc_funct3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
        acc_err  = (acc_rd && acc_wr) || f3_bad || misalign;
    end

    assign word_idx = acc_addr[ADDR_W-1:2];
    assign rd_word  = mem[word_idx];

    always_comb begin
        ld_byte = rd_word[7:0];
        case (acc_addr[1:0])
            2'd0: ld_byte = rd_word[7:0];
            2'd1: ld_byte = rd_word[15:8];
            2'd2: ld_byte = rd_word[23:16];
            2'd3: ld_byte = rd_word[31:24];
            default: ;
        endcase
        ld_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (acc_funct3[1:0])
            2'b00: load_val = acc_funct3[2] ? {{(DATA_W-8){1'b0}}, ld_byte}
                                            : {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            2'b01: load_val = acc_funct3[2] ? {{(DATA_W-16){1'b0}}, ld_half}
                                            : {{(DATA_W-16){ld_half[15]}}, ld_half};
            default: load_val = rd_word;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick
    // which lanes change.
    always_comb begin
        be      = 4'b1111;
        st_data = acc_wdata;
        case (acc_funct3[1:0])
            2'b00: begin
                be      = 4'b0001 << acc_addr[1:0];
                st_data = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be      = acc_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{acc_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign mem_we = do_access & acc_wr & ~acc_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= 4'd0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_funct3 <= 3'b000;
            req_rd     <= 1'b0;
            req_wr     <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            wr_done    <= 1'b0;
            err        <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            wr_done  <= 1'b0;
            err      <= 1'b0;
            if (capture) begin
                req_addr   <= addr;
                req_wdata  <= wr_data;
                req_funct3 <= funct3;
                req_rd     <= rd;
                req_wr     <= wr;
                cnt        <= WAIT_INIT;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                if (acc_err) begin
                    err     <= 1'b1;
                    rd_data <= '0;
                end else if (acc_rd) begin
                    rd_valid <= 1'b1;
                    rd_data  <= load_val;
                end else begin
                    wr_done <= 1'b1;
                end
            end
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_count  <= 32'd0;
            store_count <= 32'd0;
        end else begin
            if (rd_valid) begin
                load_count <= load_count + 32'd1;
            end
            if (wr_done) begin
                store_count <= store_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the core's data-memory port: accepts the rd/wr/addr/wr_data requests the pipeline drives and returns rd_data.
- Models a wait-stated byte-addressable data RAM:
  - registered request capture;
  - programmable wait-state counter;
  - stall back to the pipeline;
  - byte/half/word lane handling with sign/zero extension;
  - misalignment detection.
- Replaces the zero-latency data memory when memory-stall behaviour of the pipeline is exercised.

Parameters:
- DATA_W, 32, data width; only 32 supported.
- ADDR_W, 9, byte-address width; storage = 2**ADDR_W bytes = 2**(ADDR_W-2) words.
- WAIT_CYCLES, 2, wait states inserted between request capture and access (0..15).

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rd  input  1  load request, held by core while stall=1.
- wr  input  1  store request, held by core while stall=1.
- addr  input  ADDR_W  byte address.
- wr_data  input  DATA_W  store data, LSB-aligned.
- funct3  input  3  access size: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW.
- rd_data  output  DATA_W  extended load result, valid when rd_valid=1.
- rd_valid  output  1  one-cycle pulse: load completed.
- wr_done  output  1  one-cycle pulse: store completed.
- stall  output  1  pipeline freeze request (combinational).
- err  output  1  one-cycle pulse: misaligned, illegal funct3, or rd&wr both high.

Behaviour:
- Reset:
  - State IDLE, counter 0, captured request cleared.
  - rd_data=0, rd_valid=0, wr_done=0, err=0, stall=0.
  - RAM contents not reset.
  - Reset mid-operation drops the pending access; no RAM write occurs.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If rd|wr: capture addr, wr_data, funct3, rd, wr at the edge.
  - If WAIT_CYCLES>0: cnt<=WAIT_CYCLES, go to WAIT.
  - Else perform the access at that edge and go to RESP.
- WAIT: cnt decrements each edge. At the edge where cnt==1, perform the access and go to RESP.
- RESP:
  - Exactly one cycle. rd_valid (load), wr_done (store) or err is high; then IDLE.
  - rd/wr seen during RESP belong to the completing request and are ignored.
- Latency: completion pulse in the cycle WAIT_CYCLES+1 after the capture edge.
- stall = (IDLE & (rd|wr) & WAIT_CYCLES!=0) | WAIT. stall is low in RESP so the pipeline advances on that edge.
- Access rules:
  - Word index = addr[ADDR_W-1:2]; byte lane = addr[1:0].
  - Loads:
    - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
    - Sign- or zero-extend to 32.
    - LW returns the full word.
  - Stores: SB writes one lane; SH writes lanes {addr[1],0}/{addr[1],1}; SW writes all four. Other lanes are unchanged.
- Errors (err=1, no RAM write, rd_data=0, rd_valid=0, wr_done=0):
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=0.
  - funct3 of 011/110/111, or store funct3 >010.
  - rd=wr=1 simultaneously.
- rd_data holds its last value until the next load completion or err.
- Addresses wrap naturally within 2**ADDR_W; no out-of-range case.

Optional Feature:
- Macro DMEM_ACCESS_COUNT_EN.
- When defined, adds two outputs:
  - load_count (32): count of rd_valid pulses.
  - store_count (32): count of wr_done pulses.
- Both reset to 0 and wrap at 2**32; err completions are not counted.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- SW 0xDEADBEEF @0x010 then LW @0x010, WAIT_CYCLES=2 -> stall high 3 cycles per access; rd_valid pulse 3 cycles after capture edge with rd_data=0xDEADBEEF.
- SB 0x80 @0x013, then LB @0x013 and LBU @0x013 -> 0xFFFFFF80 and 0x00000080; LW @0x010 -> 0x80ADBEEF.
- SH 0x8001 @0x022, LH @0x022 -> 0xFFFF8001; LHU -> 0x00008001; lower half of word 0x020 unchanged.
- LW @0x011 and SH @0x023 -> err pulse, no rd_valid/wr_done; subsequent LW @0x010 unchanged; rd=wr=1 -> err.
- WAIT_CYCLES=0: LW @0x010 -> stall never high, rd_valid next cycle; back-to-back requests each complete in 2 cycles.
- Assert reset low during WAIT of SW 0x12345678 @0x040 -> outputs 0 immediately, later LW @0x040 returns prior contents; with DMEM_ACCESS_COUNT_EN, counters read 0 after reset and 1/1 after one LW and one SW.
